// File: rtl/deform_frac_int.sv
// Fractional-order integrator: rebuilds the Q8.24 signal from a x100-scaled
// derivative stream using one time-shared 32x32 signed multiplier.
//
// state  | meaning
// IDLE   | waiting for an InInd_i level change
// MUL_U  | acc <- y * INV100_K (undo the x100 scaling)
// MUL_H  | y   <- prev * ALPHA_BETA_K (history term)
// ADD    | acc <- acc + y
// MUL_G  | acc <- acc * GAIN_K
// DONE   | publish acc, latch as history, toggle OutInd_o
module deform_frac_int #(
   parameter logic signed [31:0] ALPHA_BETA_K = 32'sd8430551,
   parameter logic signed [31:0] INV100_K     = 32'sd167772,
   parameter logic signed [31:0] GAIN_K       = 32'sd33058554
) (
   input  logic               clk_sys,
   input  logic               Rst,
   input  logic signed [31:0] Deriv_i,
   input  logic               InInd_i,
   output logic signed [31:0] Signal_o,
   output logic               OutInd_o,
   output logic               Busy_o,
   output logic               Overrun_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MUL_U = 3'd1,
      S_MUL_H = 3'd2,
      S_ADD   = 3'd3,
      S_MUL_G = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic               ind_q;
   logic signed [31:0] y_q, y_d;
   logic signed [31:0] acc_q, acc_d;
   logic signed [31:0] prev_q, prev_d;
   logic signed [31:0] signal_q, signal_d;
   logic               out_ind_q, out_ind_d;
   logic               overrun_q, overrun_d;

   logic signed [31:0] mul_a, mul_b;
   logic signed [63:0] prod;
   logic signed [31:0] mul_res;
   logic               sample_det;
   logic               unused_prod_bits;

   assign sample_det = (InInd_i != ind_q);

   // Single shared multiplier; operands selected by the current state.
   always_comb begin
      mul_a = y_q;
      mul_b = INV100_K;
      case (state_q)
         S_MUL_H: begin
            mul_a = prev_q;
            mul_b = ALPHA_BETA_K;
         end
         S_MUL_G: begin
            mul_a = acc_q;
            mul_b = GAIN_K;
         end
         default: begin
            mul_a = y_q;
            mul_b = INV100_K;
         end
      endcase
   end

   assign prod             = mul_a * mul_b;
   assign mul_res          = prod[55:24];
   assign unused_prod_bits = ^{prod[63:56], prod[23:0]};

   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      acc_d     = acc_q;
      prev_d    = prev_q;
      signal_d  = signal_q;
      out_ind_d = out_ind_q;
      overrun_d = overrun_q;
      case (state_q)
         S_IDLE: begin
            if (sample_det) begin
               y_d     = Deriv_i;
               state_d = S_MUL_U;
            end
         end
         S_MUL_U: begin
            acc_d   = mul_res;
            state_d = S_MUL_H;
         end
         S_MUL_H: begin
            y_d     = mul_res;
            state_d = S_ADD;
         end
         S_ADD: begin
            acc_d   = acc_q + y_q;
            state_d = S_MUL_G;
         end
         S_MUL_G: begin
            acc_d   = mul_res;
            state_d = S_DONE;
         end
         S_DONE: begin
            signal_d  = acc_q;
            prev_d    = acc_q;
            out_ind_d = ~out_ind_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A change while busy (including DONE) is dropped; the in-flight sample still finishes.
      if (sample_det && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge Rst) begin
      if (Rst) begin
         state_q   <= S_IDLE;
         ind_q     <= 1'b0;
         y_q       <= '0;
         acc_q     <= '0;
         prev_q    <= '0;
         signal_q  <= '0;
         out_ind_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ind_q     <= InInd_i;
         y_q       <= y_d;
         acc_q     <= acc_d;
         prev_q    <= prev_d;
         signal_q  <= signal_d;
         out_ind_q <= out_ind_d;
         overrun_q <= overrun_d;
      end
   end

   assign Signal_o  = signal_q;
   assign OutInd_o  = out_ind_q;
   assign Busy_o    = (state_q != S_IDLE);
   assign Overrun_o = overrun_q;

endmodule
